// File: rtl/axi_rd_arbiter.sv
// Serialises icache (m0) and dcache (m1) AXI3 read bursts onto a single read port, one burst at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; the default build uses fixed priority m1 > m0.
module axi_rd_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ID_W-1:0]   s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arlen,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        grant
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [3:0]        arlen_q, arlen_d;
  logic              pickM1;
  logic              route0, route1;
  logic              lastDone;

`ifdef ARB_ROUND_ROBIN_EN
  // lastGrant_q holds the owner of the most recently completed burst (1 = m1).
  logic lastGrant_q, lastGrant_d;

  always_comb begin
    if (m0_arvalid && m1_arvalid) pickM1 = ~lastGrant_q;
    else                          pickM1 = m1_arvalid;
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (lastDone) lastGrant_d = grant_q[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) lastGrant_q <= 1'b1;
    else         lastGrant_q <= lastGrant_d;
  end
`else
  assign pickM1 = m1_arvalid;
`endif

  assign route0   = (state_q == DATA) && grant_q[0];
  assign route1   = (state_q == DATA) && grant_q[1];
  assign s_rready = (route0 && m0_rready) || (route1 && m1_rready);
  assign lastDone = s_rvalid && s_rready && s_rlast;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          state_d   = ADDR;
          grant_d   = pickM1 ? 2'b10 : 2'b01;
          arvalid_d = 1'b1;
          arid_d    = pickM1 ? m1_arid   : m0_arid;
          araddr_d  = pickM1 ? m1_araddr : m0_araddr;
          arlen_d   = pickM1 ? m1_arlen  : m0_arlen;
        end
      end
      ADDR: begin
        if (arvalid_q && s_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        // The owner is released only on the last beat, so the next grant comes from IDLE a cycle later.
        if (lastDone) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = 2'b00;
        arvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
    end
  end

  assign s_arid    = arid_q;
  assign s_araddr  = araddr_q;
  assign s_arlen   = arlen_q;
  assign s_arvalid = arvalid_q;
  assign grant     = grant_q;

  assign m0_arready = (state_q == ADDR) && grant_q[0] && s_arready;
  assign m1_arready = (state_q == ADDR) && grant_q[1] && s_arready;

  // The non-owner sees an all-zero R channel rather than a copy of the slave's beats.
  assign m0_rvalid = route0 && s_rvalid;
  assign m0_rlast  = route0 && s_rlast;
  assign m0_rid    = route0 ? s_rid   : '0;
  assign m0_rdata  = route0 ? s_rdata : '0;
  assign m0_rresp  = route0 ? s_rresp : 2'b00;

  assign m1_rvalid = route1 && s_rvalid;
  assign m1_rlast  = route1 && s_rlast;
  assign m1_rid    = route1 ? s_rid   : '0;
  assign m1_rdata  = route1 ? s_rdata : '0;
  assign m1_rresp  = route1 ? s_rresp : 2'b00;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR requests and R beats are queued at stimulus time
// and popped by a monitor on every handshake; a small AXI slave model serves the bursts.
module tb_axi_rd_arbiter;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic [ID_W-1:0]   m0_arid, m1_arid, m0_rid, m1_rid, s_arid, s_rid;
  logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
  logic [3:0]        m0_arlen, m1_arlen, s_arlen;
  logic              m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]        m0_rresp, m1_rresp, s_rresp;
  logic              m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic              s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready), .grant(grant)
  );

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [3:0] len; } ar_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } beat_t;
  typedef struct packed { logic [3:0] id; logic [3:0] len; logic [31:0] base; } burst_t;

  ar_t         expAr[$];
  beat_t       expR0[$];
  beat_t       expR1[$];
  logic [31:0] slaveBase[$];

  int checks  = 0;
  int errors  = 0;
  int m0Beats = 0;
  int m1Beats = 0;
  int m1ArCnt = 0;
  int arDelay = 1;
  bit slaveFlush = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s %s", name, what);
  endtask

  // Beat k of a burst carries base+k, resp=k[1:0], and rlast on k == len.
  task automatic expectBurst(input int who, input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [31:0] base, input int nBeats);
    beat_t b;
    expAr.push_back({id, addr, len});
    slaveBase.push_back(base);
    for (int k = 0; k < nBeats; k++) begin
      b.id   = id;
      b.data = base + 32'(k);
      b.resp = 2'(k);
      b.last = (k == int'(len));
      if (who == 0) expR0.push_back(b);
      else          expR1.push_back(b);
    end
  endtask

  // Master request: held until arready unless the master withdraws after one cycle.
  task automatic applyStimulus(input int who, input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input bit withdraw);
    int n;
    bit acc;
    @(posedge clk); #1;
    if (who == 0) begin m0_arid = id; m0_araddr = addr; m0_arlen = len; m0_arvalid = 1'b1; end
    else          begin m1_arid = id; m1_araddr = addr; m1_arlen = len; m1_arvalid = 1'b1; end
    if (withdraw) begin
      @(posedge clk); #1;
    end else begin
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = (who == 0) ? m0_arready : m1_arready;
        n++;
      end
      if (!acc) failNow("ar_accept", "actual=no arready expected=arready within 200 cycles");
      @(posedge clk); #1;
    end
    if (who == 0) m0_arvalid = 1'b0;
    else          m1_arvalid = 1'b0;
  endtask

  task automatic waitLast(input int who);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = (who == 0) ? (m0_rvalid && m0_rready && m0_rlast) : (m1_rvalid && m1_rready && m1_rlast);
    end
    if (!seen) failNow("last_beat", "actual=no rlast expected=rlast within 400 cycles");
  endtask

  task automatic waitIdle();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
      done = (grant == 2'b00) && (expAr.size() == 0) && (expR0.size() == 0) && (expR1.size() == 0);
    end
    if (!done) failNow("idle_wait", "actual=busy or beats missing expected=idle with scoreboard empty");
  endtask

  task automatic checkGap(input int firstWho, input logic [31:0] secondAddr);
    logic [1:0] firstGrant  = (firstWho == 0) ? 2'b01 : 2'b10;
    logic [1:0] secondGrant = (firstWho == 0) ? 2'b10 : 2'b01;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("contend_first_grant", 64'(grant), 64'(firstGrant));
    waitLast(firstWho);
    @(negedge clk);
    checkOutput("contend_gap_idle", 64'(grant), 64'(2'b00));
    @(negedge clk);
    checkOutput("contend_second_grant", 64'({grant, s_arvalid, s_araddr}), 64'({secondGrant, 1'b1, secondAddr}));
  endtask

  // Slave model: arready after arDelay cycles of s_arvalid, then one burst of beats from slaveBase.
  initial begin : slaveModel
    burst_t     pend[$];
    burst_t     cur;
    logic       arHs, rHs;
    logic [3:0] idCap, lenCap;
    logic [31:0] base;
    int         beat, arCnt;
    bit         active;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_rdata = '0; s_rid = '0; s_rresp = 2'b00;
    beat = 0; arCnt = 0; active = 1'b0; cur = '0;
    forever begin
      @(negedge clk);
      arHs   = s_arvalid && s_arready;
      rHs    = s_rvalid && s_rready;
      idCap  = s_arid;
      lenCap = s_arlen;
      @(posedge clk); #1;
      if (slaveFlush) begin
        pend.delete();
        active = 1'b0; arCnt = 0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        slaveFlush = 1'b0;
      end else begin
        if (arHs) begin
          s_arready = 1'b0;
          arCnt = 0;
          base = (slaveBase.size() > 0) ? slaveBase.pop_front() : 32'hBAD0_0000;
          pend.push_back({idCap, lenCap, base});
        end else if (s_arvalid) begin
          if (arCnt >= arDelay) s_arready = 1'b1;
          else arCnt++;
        end
        if (rHs && active) begin
          if (beat == int'(cur.len)) begin
            active = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
          end else begin
            beat++;
          end
        end
        if (!active && pend.size() > 0) begin
          cur = pend.pop_front();
          active = 1'b1;
          beat = 0;
        end
        if (active) begin
          s_rvalid = 1'b1;
          s_rid    = cur.id;
          s_rdata  = cur.base + 32'(beat);
          s_rresp  = 2'(beat);
          s_rlast  = (beat == int'(cur.len));
        end
      end
    end
  end

  // Monitor: every AR handshake and every routed R handshake is popped against the scoreboard.
  initial begin : monitor
    ar_t   ar;
    beat_t b;
    forever begin
      @(negedge clk);
      if (m1_arready) m1ArCnt++;
      if (s_arvalid && s_arready) begin
        if (expAr.size() == 0) failNow("sb_ar", $sformatf("actual=addr %0h expected=no request", s_araddr));
        else begin
          ar = expAr.pop_front();
          checkOutput("sb_ar", 64'({s_arid, s_araddr, s_arlen}), 64'(ar));
        end
      end
      if (m0_rvalid && m0_rready) begin
        m0Beats++;
        if (expR0.size() == 0) failNow("sb_r0", $sformatf("actual=beat %0h expected=no beat", m0_rdata));
        else begin
          b = expR0.pop_front();
          checkOutput("sb_r0", 64'({m0_rid, m0_rdata, m0_rresp, m0_rlast}), 64'(b));
        end
      end
      if (m1_rvalid && m1_rready) begin
        m1Beats++;
        if (expR1.size() == 0) failNow("sb_r1", $sformatf("actual=beat %0h expected=no beat", m1_rdata));
        else begin
          b = expR1.pop_front();
          checkOutput("sb_r1", 64'({m1_rid, m1_rdata, m1_rresp, m1_rlast}), 64'(b));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int firstWho;
    int b0, b1, c1;
    int n;
    resetn = 1'b0;
    m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
    m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ar", 64'({grant, s_arvalid, s_arid, s_araddr, s_arlen}), 64'(0));
    checkOutput("reset_ready", 64'({s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}), 64'(0));
    @(posedge clk); #1;
    resetn = 1'b1;

    $display("[TB] simultaneous requests");
`ifdef ARB_ROUND_ROBIN_EN
    firstWho = 0;
`else
    firstWho = 1;
`endif
    for (int r = 0; r < 2; r++) begin
      if (firstWho == 1) begin
        expectBurst(1, 4'd6, 32'h0000_2000, 4'd1, 32'h0000_2200, 2);
        expectBurst(0, 4'd1, 32'h0000_1000, 4'd1, 32'h0000_1100, 2);
      end else begin
        expectBurst(0, 4'd1, 32'h0000_1000, 4'd1, 32'h0000_1100, 2);
        expectBurst(1, 4'd6, 32'h0000_2000, 4'd1, 32'h0000_2200, 2);
      end
      fork
        applyStimulus(0, 4'd1, 32'h0000_1000, 4'd1, 1'b0);
        applyStimulus(1, 4'd6, 32'h0000_2000, 4'd1, 1'b0);
        checkGap(firstWho, (firstWho == 1) ? 32'h0000_1000 : 32'h0000_2000);
      join
      waitIdle();
    end

    $display("[TB] single icache burst");
    b0 = m0Beats; b1 = m1Beats;
    expectBurst(0, 4'd3, 32'h1FC0_0040, 4'hF, 32'h0000_0100, 16);
    fork
      applyStimulus(0, 4'd3, 32'h1FC0_0040, 4'hF, 1'b0);
      begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("burst_idle_before", 64'({grant, s_arvalid}), 64'(0));
        @(negedge clk);
        checkOutput("burst_ar_latency", 64'({grant, s_arvalid, s_arid, s_araddr, s_arlen}),
                    64'({2'b01, 1'b1, 4'd3, 32'h1FC0_0040, 4'hF}));
      end
    join
    waitIdle();
    checkOutput("burst_m0_beats", 64'(m0Beats - b0), 64'(16));
    checkOutput("burst_m1_beats", 64'(m1Beats - b1), 64'(0));

    $display("[TB] backpressure");
    arDelay = 5;
    b1 = m1Beats; c1 = m1ArCnt;
    expectBurst(1, 4'd5, 32'h0000_3000, 4'd3, 32'h0000_0800, 4);
    fork
      applyStimulus(1, 4'd5, 32'h0000_3000, 4'd3, 1'b0);
      begin
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("bp_ar_stable", 64'({s_arvalid, s_araddr, m1_arready}), 64'({1'b1, 32'h0000_3000, 1'b0}));
        end
      end
    join
    n = 0;
    while (m1Beats < b1 + 4 && n < 200) begin
      m1_rready = ~m1_rready;
      @(posedge clk); #1;
      n++;
    end
    m1_rready = 1'b1;
    waitIdle();
    checkOutput("bp_m1_beats", 64'(m1Beats - b1), 64'(4));
    checkOutput("bp_arready_pulses", 64'(m1ArCnt - c1), 64'(1));
    arDelay = 1;

    $display("[TB] uncached single beat");
    b0 = m0Beats;
    expectBurst(0, 4'd2, 32'hBFAF_8000, 4'd0, 32'hDEAD_BEEF, 1);
    fork
      applyStimulus(0, 4'd2, 32'hBFAF_8000, 4'd0, 1'b0);
      begin
        waitLast(0);
        @(negedge clk);
        checkOutput("single_back_idle", 64'({grant, s_rready, m0_rvalid}), 64'(0));
      end
    join
    waitIdle();
    checkOutput("single_m0_beats", 64'(m0Beats - b0), 64'(1));

    $display("[TB] withdrawn request");
    b0 = m0Beats;
    expectBurst(0, 4'd9, 32'h0000_4000, 4'd2, 32'h0000_0500, 3);
    applyStimulus(0, 4'd9, 32'h0000_4000, 4'd2, 1'b1);
    waitIdle();
    checkOutput("withdraw_m0_beats", 64'(m0Beats - b0), 64'(3));

    $display("[TB] reset mid-burst");
    b0 = m0Beats;
    expectBurst(0, 4'd1, 32'h0000_5000, 4'hF, 32'h0000_0600, 7);
    applyStimulus(0, 4'd1, 32'h0000_5000, 4'hF, 1'b0);
    n = 0;
    while (m0Beats < b0 + 6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (m0Beats < b0 + 6) failNow("rst_reach_beat", "actual=too few beats expected=6 beats before reset");
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_outputs", 64'({s_arvalid, s_rready, grant, m0_rvalid}), 64'(0));
    repeat (5) @(negedge clk);
    checkOutput("rst_no_route", 64'(m0Beats - b0), 64'(7));
    slaveFlush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b1 = m1Beats;
    expectBurst(1, 4'd7, 32'h0000_6000, 4'd1, 32'h0000_0700, 2);
    applyStimulus(1, 4'd7, 32'h0000_6000, 4'd1, 1'b0);
    waitIdle();
    checkOutput("rst_new_request", 64'(m1Beats - b1), 64'(2));

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 64'(expAr.size() + expR0.size() + expR1.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI3 read channel (AR and R) between the instruction cache (master 0) and the data cache (master 1).
- Transactions are serialised: one outstanding burst at a time.
- The AR request is registered at grant, and R beats are routed back to the granted master only.
- Sits between the cache pair and the top-level AXI read port; the write channels bypass this block.

Parameters:
- ID_W, 4, AXI ID width.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset; one clock, all state sampled on posedge clk.
- m0_arid/m1_arid  in  ID_W  master read ID
- m0_araddr/m1_araddr  in  ADDR_W  master address
- m0_arlen/m1_arlen  in  4  master burst length minus 1
- m0_arvalid/m1_arvalid  in  1  master request
- m0_arready/m1_arready  out  1  request accepted by slave
- m0_rid/m1_rid  out  ID_W  routed read ID
- m0_rdata/m1_rdata  out  DATA_W  routed data
- m0_rresp/m1_rresp  out  2  routed response
- m0_rlast/m1_rlast  out  1  routed last
- m0_rvalid/m1_rvalid  out  1  routed valid
- m0_rready/m1_rready  in  1  master ready
- s_arid  out  ID_W  to AXI
- s_araddr  out  ADDR_W  to AXI
- s_arlen  out  4  to AXI
- s_arvalid  out  1  to AXI
- s_arready  in  1  from AXI
- s_rid  in  ID_W  from AXI
- s_rdata  in  DATA_W  from AXI
- s_rresp  in  2  from AXI
- s_rlast  in  1  from AXI
- s_rvalid  in  1  from AXI
- s_rready  out  1  to AXI
- grant  out  2  one-hot owner (bit0=m0, bit1=m1); 0 when idle.

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset (resetn=0 at posedge):
  - State goes to IDLE; grant=0.
  - s_arvalid=0; s_arid, s_araddr, s_arlen all 0.
  - last_grant=1, so m0 wins the first tie.
  - Reset mid-burst abandons the transfer; beats arriving after reset are not routed.
- IDLE:
  - If any mX_arvalid, pick the winner (see arbitration) and capture its arid, araddr and arlen into the s_ar* registers.
  - Set grant and s_arvalid=1; go to ADDR.
  - Latency: arvalid seen in cycle N gives s_arvalid=1 in cycle N+1.
- ADDR:
  - s_arvalid is held high; the s_ar* fields are stable.
  - mX_arready = s_arready & grant[X], combinational.
  - On s_arvalid & s_arready, clear s_arvalid and go to DATA.
- DATA:
  - The granted master receives s_rid, s_rdata, s_rresp, s_rlast and s_rvalid.
  - s_rready = granted master's rready.
  - On s_rvalid & s_rready & s_rlast, go to IDLE, clear grant and update last_grant.
- Non-granted master: rvalid, rlast, rdata, rid and rresp are all 0; arready is 0 in every state except ADDR-granted.
- s_rready=0 in IDLE and ADDR.
- Master drops arvalid after grant (the caches may withdraw): the captured request is still issued and its burst is still routed. The master must tolerate unrequested beats. s_rready follows that master's rready, and the caches tie rready to 1.
- A new grant is not possible in the cycle the last beat completes. There is a minimum one IDLE cycle between bursts.
- s_rid is not checked; all beats go to the current owner.
- arlen=0 (uncached single beat): DATA lasts until the first beat, which carries rlast.
- Arbitration (default, macro absent): fixed priority; m1 (dcache) wins whenever both arvalid are high in IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request in IDLE, grant the master not recorded in last_grant. last_grant updates at each burst completion. A single requester is always granted regardless of last_grant.
- Undefined: fixed priority m1 > m0; last_grant is unused and may be removed.

Test Plan:
- Single icache burst:
  - Stimulus: m0 requests arid=3, araddr=0x1FC0_0040, arlen=0xF; slave takes arready one cycle after s_arvalid, then returns 16 beats 0x100..0x10F.
  - Required: s_araddr=0x1FC0_0040 and s_arlen=0xF one cycle after request; m0 sees exactly 16 rvalid beats with matching data and rlast on the 16th; m1_rvalid stays 0; grant returns to 0.
- Simultaneous request:
  - Stimulus: m0 (0x1000) and m1 (0x2000) assert in the same cycle.
  - Required, default: 0x2000 issued first, then 0x1000 after the m1 burst's rlast plus one IDLE cycle.
  - Required, ARB_ROUND_ROBIN_EN: first grant m0 (last_grant=1 at reset); with repeated contention, grants alternate m0, m1, m0.
- Backpressure:
  - Stimulus: s_arready held 0 for 5 cycles, then m1 rready toggles 1/0 during a 4-beat burst.
  - Required: s_arvalid and s_araddr stable for all 5 cycles; m1_arready pulses exactly once; beats accepted only when rready=1; no beat lost or duplicated.
- Uncached single beat:
  - Stimulus: m0 arid=2, arlen=0, araddr=0xBFAF_8000; slave returns 0xDEADBEEF with rlast.
  - Required: one beat delivered to m0; FSM back in IDLE the next cycle.
- Withdrawn request:
  - Stimulus: m0 asserts arvalid for 1 cycle only.
  - Required: request still issued, and the burst is delivered to m0.
- Reset mid-burst:
  - Stimulus: resetn=0 during beat 7 of 16.
  - Required: next cycle s_arvalid=0, s_rready=0, grant=0; no further beats routed; a new request after reset is granted normally.
